// File: rtl/mod_counter_pkg.sv
// Shared constants for the modulo event counter family: saturation mode and
// event-qualification mode selectors.
package mod_counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  localparam int EVT_LEVEL = 0;
  localparam int EVT_EDGE  = 1;

endpackage : mod_counter_pkg

// File: rtl/edge_detect.sv
// Rising-edge detector: din is registered every cycle, rise = din & ~din_q.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic din_q;
  logic din_d;

  always_comb begin
    din_d = din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      din_q <= 1'b0;
    end else begin
      din_q <= din_d;
    end
  end

  // Combinational on purpose so a step lands on the same edge as the rising input.
  assign rise = din & ~din_q;

endmodule : edge_detect

// File: rtl/mod_event_counter.sv
// Up/down modulo-MODULUS event counter with parallel load, optional saturation,
// optional rising-edge qualification, a one-cycle wrap pulse and a sticky flag.
module mod_event_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH       = 3,
  parameter int MODULUS     = 5,
  parameter int SATURATE    = MODE_WRAP,
  parameter int EDGE_DETECT = EVT_LEVEL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             input1,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear_sticky,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             overflow_sticky
);

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH + 1)'(MODULUS);
  localparam logic             SAT_MODE  = (SATURATE == MODE_SAT);
  localparam logic             EDGE_MODE = (EDGE_DETECT == EVT_EDGE);

  logic             rise;
  logic             evt;
  logic             step;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             sticky_q, sticky_d;

  // The detector always runs so its history stays current through load and
  // enable=0 cycles.
  edge_detect u_edge_detect (
    .clk   (clk),
    .reset (reset),
    .din   (input1),
    .rise  (rise)
  );

  assign evt  = EDGE_MODE ? rise : input1;
  assign step = enable & evt & ~load;

  always_comb begin
    count_d  = count_q;
    wrap_d   = 1'b0;
    sticky_d = sticky_q & ~clear_sticky;

    if (load) begin
      count_d = ({1'b0, load_value} >= MOD_EXT) ? MAX_COUNT : load_value;
    end else if (step) begin
      if (up) begin
        if (count_q == MAX_COUNT) begin
          sticky_d = 1'b1;
          if (!SAT_MODE) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          sticky_d = 1'b1;
          if (!SAT_MODE) begin
            count_d = MAX_COUNT;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      wrap_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wrap_q   <= wrap_d;
      sticky_q <= sticky_d;
    end
  end

  assign count           = count_q;
  assign wrap            = wrap_q;
  assign overflow_sticky = sticky_q;

endmodule : mod_event_counter

// File: tb/tb_mod_event_counter.sv
// Directed bench for mod_event_counter: default, saturating and edge-qualified
// instances, each driven by its own stimulus set.
module tb_mod_event_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Instance 0: defaults (wrap, level)
  logic       r0 = 1'b1, en0 = 1'b0, in0 = 1'b0, up0 = 1'b1, ld0 = 1'b0, cs0 = 1'b0;
  logic [2:0] lv0 = 3'd0, cnt0;
  logic       wr0, st0;
  // Instance 1: saturating
  logic       r1 = 1'b1, en1 = 1'b0, in1 = 1'b0, up1 = 1'b1, ld1 = 1'b0, cs1 = 1'b0;
  logic [2:0] lv1 = 3'd0, cnt1;
  logic       wr1, st1;
  // Instance 2: rising-edge events
  logic       r2 = 1'b1, en2 = 1'b0, in2 = 1'b0, up2 = 1'b1, ld2 = 1'b0, cs2 = 1'b0;
  logic [2:0] lv2 = 3'd0, cnt2;
  logic       wr2, st2;

  mod_event_counter u_dut0 (
    .clk(clk), .reset(r0), .enable(en0), .input1(in0), .up(up0), .load(ld0),
    .load_value(lv0), .clear_sticky(cs0), .count(cnt0), .wrap(wr0), .overflow_sticky(st0)
  );

  mod_event_counter #(.SATURATE(1)) u_dut1 (
    .clk(clk), .reset(r1), .enable(en1), .input1(in1), .up(up1), .load(ld1),
    .load_value(lv1), .clear_sticky(cs1), .count(cnt1), .wrap(wr1), .overflow_sticky(st1)
  );

  mod_event_counter #(.EDGE_DETECT(1)) u_dut2 (
    .clk(clk), .reset(r2), .enable(en2), .input1(in2), .up(up2), .load(ld2),
    .load_value(lv2), .clear_sticky(cs2), .count(cnt2), .wrap(wr2), .overflow_sticky(st2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk0(input string tag, input int c, input int w, input int s);
    chk({tag, ".count"}, 32'(cnt0), 32'(c));
    chk({tag, ".wrap"},  32'(wr0),  32'(w));
    chk({tag, ".stky"},  32'(st0),  32'(s));
  endtask

  task automatic chk1(input string tag, input int c, input int w, input int s);
    chk({tag, ".count"}, 32'(cnt1), 32'(c));
    chk({tag, ".wrap"},  32'(wr1),  32'(w));
    chk({tag, ".stky"},  32'(st1),  32'(s));
  endtask

  initial begin
    int exp_c [5] = '{1, 2, 3, 4, 0};
    int exp_w [5] = '{0, 0, 0, 0, 1};

    // Reset all instances
    tick();
    tick();
    chk0("rst0", 0, 0, 0);
    chk1("rst1", 0, 0, 0);
    chk("rst2.count", 32'(cnt2), 0);
    chk("rst2.wrap",  32'(wr2),  0);
    r0 = 1'b0; r1 = 1'b0; r2 = 1'b0;

    // ---- Instance 0: count up through wrap
    en0 = 1'b1; up0 = 1'b1; in0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk0($sformatf("up_wrap%0d", i), exp_c[i], exp_w[i], (i == 4) ? 1 : 0);
    end
    in0 = 1'b0;
    tick();
    chk0("idle_after_wrap", 0, 0, 1);

    // Down wrap from 0, then clear sticky
    up0 = 1'b0; in0 = 1'b1;
    tick();
    chk0("down_wrap", 4, 1, 1);
    in0 = 1'b0; cs0 = 1'b1;
    tick();
    chk0("clear_sticky", 4, 0, 0);

    // Coincident set and clear: set wins
    up0 = 1'b1; in0 = 1'b1; cs0 = 1'b1;
    tick();
    chk0("set_clear_same", 0, 1, 1);
    in0 = 1'b0;
    tick();
    chk0("clear_again", 0, 0, 0);
    cs0 = 1'b0;

    // enable=0 holds count
    en0 = 1'b0; in0 = 1'b1;
    tick();
    chk0("enable_low_hold", 0, 0, 0);

    // Loads: clamp, enable-independent, event dropped
    in0 = 1'b0; ld0 = 1'b1; lv0 = 3'd7;
    tick();
    chk0("load7_clamp_en0", 4, 0, 0);
    en0 = 1'b1; in0 = 1'b1; up0 = 1'b1; lv0 = 3'd2;
    tick();
    chk0("load2_with_event", 2, 0, 0);
    lv0 = 3'd5;
    tick();
    chk0("load5_clamp", 4, 0, 0);
    lv0 = 3'd0;
    tick();
    chk0("load0_at_max_no_wrap", 0, 0, 0);

    // Reach count 3 with sticky set, then reset mid-count
    lv0 = 3'd4;
    tick();
    ld0 = 1'b0;
    tick();
    chk0("wrap_for_reset", 0, 1, 1);
    tick();
    tick();
    tick();
    chk0("count3_sticky", 3, 0, 1);
    r0 = 1'b1; ld0 = 1'b1; lv0 = 3'd2;
    tick();
    chk0("reset_midcount", 0, 0, 0);
    r0 = 1'b0; ld0 = 1'b0;
    tick();
    chk0("resume_after_reset", 1, 0, 0);
    en0 = 1'b0; in0 = 1'b0;

    // ---- Instance 1: saturation
    ld1 = 1'b1; lv1 = 3'd4;
    tick();
    chk1("sat_load4", 4, 0, 0);
    ld1 = 1'b0; en1 = 1'b1; up1 = 1'b1; in1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1($sformatf("sat_hold_top%0d", i), 4, 0, 1);
    end
    in1 = 1'b0; cs1 = 1'b1;
    tick();
    chk1("sat_clear", 4, 0, 0);
    cs1 = 1'b0; ld1 = 1'b1; lv1 = 3'd0;
    tick();
    ld1 = 1'b0; up1 = 1'b0; in1 = 1'b1;
    tick();
    chk1("sat_hold_bottom", 0, 0, 1);
    up1 = 1'b1;
    tick();
    chk1("sat_up_from0", 1, 0, 1);
    en1 = 1'b0; in1 = 1'b0;

    // ---- Instance 2: rising-edge qualification
    en2 = 1'b1; up2 = 1'b1; in2 = 1'b1;
    tick();
    chk("edge_first_rise", 32'(cnt2), 1);
    for (int i = 0; i < 9; i++) tick();
    chk("edge_held_high", 32'(cnt2), 1);
    in2 = 1'b0;
    tick();
    tick();
    chk("edge_low", 32'(cnt2), 1);
    in2 = 1'b1;
    tick();
    chk("edge_second_rise", 32'(cnt2), 2);
    in2 = 1'b0;
    tick();
    chk("edge_fall", 32'(cnt2), 2);
    // History updates during load: no step on the following high cycle
    in2 = 1'b1; ld2 = 1'b1; lv2 = 3'd0;
    tick();
    chk("edge_load_rise", 32'(cnt2), 0);
    ld2 = 1'b0;
    tick();
    chk("edge_after_load", 32'(cnt2), 0);
    // History updates with enable low
    in2 = 1'b0;
    tick();
    en2 = 1'b0; in2 = 1'b1;
    tick();
    chk("edge_en0_rise", 32'(cnt2), 0);
    en2 = 1'b1;
    tick();
    chk("edge_after_en0", 32'(cnt2), 0);
    chk("edge_wrap_never", 32'(wr2), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_mod_event_counter

// File: doc/mod_event_counter.md
MOD_EVENT_COUNTER -- requirements
Module: mod_event_counter

Interface
REQ-001 Clocking SHALL be: one clock; reset is synchronous and active-high.
REQ-002 Parameter WIDTH, default 3: bit width of count and load_value.
REQ-003 Parameter MODULUS, default 5: count range 0..MODULUS-1; legal range 2..2**WIDTH.
REQ-004 Parameter SATURATE, default 0: 0 = wrap at range ends; 1 = hold at range ends.
REQ-005 Parameter EDGE_DETECT, default 0: 0 = count every cycle input1 is high; 1 = count rising edges of input1 only.
REQ-006 clk  in  1  rising-edge system clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 enable  in  1  permits event counting.
REQ-009 input1  in  1  event input.
REQ-010 up  in  1  direction: 1 = increment, 0 = decrement.
REQ-011 load  in  1  parallel load request.
REQ-012 load_value  in  WIDTH  value to load.
REQ-013 clear_sticky  in  1  clears overflow_sticky.
REQ-014 count  out  WIDTH  registered current count.
REQ-015 wrap  out  1  registered one-cycle pulse on a boundary crossing.
REQ-016 overflow_sticky  out  1  registered sticky flag for any wrap or saturation event.

Function
REQ-017 The event SHALL be input1 when EDGE_DETECT=0, and input1 AND NOT input1_d when EDGE_DETECT=1, where input1_d is input1 registered every cycle.
REQ-018 A step SHALL occur on a clock edge where enable=1 AND event=1 AND load=0; count updates on that same edge (one-edge latency, no extra delay for EDGE_DETECT).
REQ-019 Priority SHALL be reset > load > step > hold.
REQ-020 Load SHALL set count to load_value, or to MODULUS-1 when load_value >= MODULUS; load ignores enable and drops a coincident event.
REQ-021 Up-step SHALL produce count+1 for count < MODULUS-1; at MODULUS-1, produce 0 with SATURATE=0, or hold MODULUS-1 with SATURATE=1.
REQ-022 Down-step SHALL produce count-1 for count > 0; at 0, produce MODULUS-1 with SATURATE=0, or hold 0 with SATURATE=1.
REQ-023 wrap SHALL be 1 for exactly the cycle after a wrap step (REQ-021/022, SATURATE=0) and 0 otherwise; it is never asserted when SATURATE=1 or on a load.
REQ-024 overflow_sticky SHALL be set by any wrap step or blocked saturating step, and cleared by clear_sticky; a coincident set and clear SHALL leave it set.
REQ-025 Count SHALL never leave 0..MODULUS-1 except through an illegal parameter choice.
REQ-026 Outputs SHALL be driven directly from flops (glitch-free); there is no combinational input-to-output path.
REQ-027 input1_d SHALL update on every edge, including load cycles and enable=0 cycles.

Reset
REQ-028 On a clock edge with reset=1: count=0, wrap=0, overflow_sticky=0, input1_d=0; all other inputs are ignored.
REQ-029 Reset asserted mid-count SHALL take effect on that edge; counting resumes from 0 on the first edge with reset=0.

Structure
REQ-030 Shared package mod_counter_pkg SHALL hold the SATURATE mode constants (MODE_WRAP=0, MODE_SAT=1) and the EDGE_DETECT constants (EVT_LEVEL=0, EVT_EDGE=1).
REQ-031 The rising-edge detector SHALL be a sub-module named edge_detect (ports clk, reset, din, rise); the counter datapath and flags stay in mod_event_counter.

Verification
REQ-032 Defaults, up=1, enable=1, input1 high 5 cycles from 0 -> count 1,2,3,4,0; wrap=1 only in the cycle count shows 0; overflow_sticky=1.
REQ-033 Defaults, count=0, up=0, one event -> count=4, wrap pulse, overflow_sticky=1; clear_sticky -> overflow_sticky=0 next cycle.
REQ-034 SATURATE=1, count=4, up=1, 3 events -> count stays 4, wrap never 1, overflow_sticky=1.
REQ-035 EDGE_DETECT=1, input1 held high 10 cycles, then low 2, then high 1 -> count 0 to 1 to 2 total, one step per rising edge.
REQ-036 load_value=7 with MODULUS=5 -> count=4; load=1 with a coincident event and load_value=2 -> count=2; enable=0 with load=1 -> load still applied.
REQ-037 Count at 3 with overflow_sticky=1, reset pulsed one cycle with input1 high -> count=0, flags 0 on that edge, then counting resumes from 1.
